// File: rtl/data_mem_unit.sv
// Data memory stage: byte-lane stores into a word RAM and registered, extended loads.
// Define DM_CLEAR_EN to build the post-reset RAM clear sequencer (otherwise busy is tied low).
module data_mem_unit #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Inst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  input  logic        unaligned,
  input  logic        valid,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  output logic        dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  is_load;
  logic                  is_store;
  logic                  run;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wval;

  logic [3:0]            st_be;
  logic [31:0]           st_rep;
  logic [31:0]           rd_word;
  logic [31:0]           rd_shift;
  logic [15:0]           rd_half;
  logic [31:0]           ld_ext;
  logic                  ld_go;
  logic                  access_fault;

  logic [31:0]           rdata_q;
  logic                  rdata_valid_q;
  logic                  fault_q;

  logic                  unused_bits;
  assign unused_bits = ^{address[31:ADDR_WIDTH+2], Inst[25:0]};

  assign word_idx = address[ADDR_WIDTH+1:2];
  assign is_load  = (Inst[31:29] == 3'b100);
  assign is_store = (size != 3'b000);

`ifdef DM_CLEAR_EN
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;

  // The clear walks every word once; the last word is written on the edge that enters RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (&clr_cnt_q) state_q <= ST_RUN;
    end
  end

  assign run     = (state_q == ST_RUN);
  assign clr_cnt = clr_cnt_q;
`else
  assign run     = 1'b1;
  assign clr_cnt = '0;
`endif

  assign busy      = ~run;
  assign dbg_state = run ? ST_RUN : ST_CLEAR;

  // Store lane enables with the payload replicated so any enabled lane sees its bytes.
  always_comb begin
    st_be  = 4'b1111;
    st_rep = wdata;
    case (size)
      3'b001: begin
        st_be  = 4'b0001 << address[1:0];
        st_rep = {4{wdata[7:0]}};
      end
      3'b010: begin
        st_be  = address[1] ? 4'b1100 : 4'b0011;
        st_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_we   = run ? (valid & is_store & ~unaligned) : 1'b1;
  assign mem_addr = run ? word_idx : clr_cnt;
  assign mem_be   = run ? st_be : 4'b1111;
  assign mem_wval = run ? st_rep : 32'h0;

  // Writes are gated by reset_n so a store coinciding with reset assertion is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wval[8*b +: 8];
      end
    end
  end

  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> {address[1:0], 3'b000};
  assign rd_half  = address[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_ext = rd_word;
    case (Inst[27:26])
      2'b00:   ld_ext = Inst[28] ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = Inst[28] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_ext = rd_word;
    endcase
  end

  assign ld_go        = run & valid & is_load & ~unaligned;
  assign access_fault = run & valid & (is_load | is_store) & unaligned;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      rdata_valid_q <= ld_go;
      fault_q       <= access_fault;
      if (ld_go) rdata_q <= ld_ext;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit; clear-sequencer checks are built when DM_CLEAR_EN is defined.
module tb_data_mem_unit;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] Inst = 32'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [2:0]  size = 3'b000;
  logic        unaligned = 1'b0;
  logic        valid = 1'b0;
  logic        busy;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;
  logic        dbg_state;

  int total = 0;
  int bad = 0;

  data_mem_unit #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .Inst(Inst), .address(address), .wdata(wdata),
    .size(size), .unaligned(unaligned), .valid(valid), .busy(busy), .rdata(rdata),
    .rdata_valid(rdata_valid), .fault(fault), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // driver tasks: called at a negedge, return at the next negedge with results visible
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] sz, input logic un);
    Inst      = {op, 26'h0};
    address   = addr;
    wdata     = wd;
    size      = sz;
    unaligned = un;
    valid     = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    Inst      = 32'h0;
    size      = 3'b000;
    unaligned = 1'b0;
    valid     = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    total++; if (rdata_valid !== 1'b0) begin bad++; $display("FAIL reset_rdata_valid got=%b exp=0", rdata_valid); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
`ifdef DM_CLEAR_EN
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    reset_n = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    total++; if (cnt != 1024) begin bad++; $display("FAIL clear_cycles got=%0d exp=1024", cnt); end
    total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL clear_state got=%b exp=1", dbg_state); end
    issue(OP_LW, 32'h0000_0FF0, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'h0 || rdata_valid !== 1'b1) begin
      bad++; $display("FAIL clear_lw_3fc got=%h/%b exp=00000000/1", rdata, rdata_valid);
    end
    idle();
`else
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    idle();
    total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL run_state got=%b exp=1", dbg_state); end
`endif
  endtask

  task automatic test_sw_lb();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'h0000_0001;
    exp_v[1] = 32'h0000_007F;
    exp_v[2] = 32'hFFFF_FFFF;
    exp_v[3] = 32'hFFFF_FF80;
    issue(OP_SW, 32'h10, 32'h80FF_7F01, 3'b100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      issue(OP_LB, 32'h10 + 32'(i), 32'h0, 3'b000, 1'b0);
      total++; if (rdata !== exp_v[i] || rdata_valid !== 1'b1) begin
        bad++; $display("FAIL lb_lane%0d got=%h/%b exp=%h/1", i, rdata, rdata_valid, exp_v[i]);
      end
    end
    idle();
  endtask

  task automatic test_unsigned();
    issue(OP_LBU, 32'h13, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_13 got=%h exp=00000080", rdata); end
    issue(OP_LH, 32'h12, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'hFFFF_80FF) begin bad++; $display("FAIL lh_12 got=%h exp=ffff80ff", rdata); end
    issue(OP_LHU, 32'h12, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'h0000_80FF) begin bad++; $display("FAIL lhu_12 got=%h exp=000080ff", rdata); end
    issue(OP_LHU, 32'h10, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'h0000_7F01) begin bad++; $display("FAIL lhu_10 got=%h exp=00007f01", rdata); end
    idle();
  endtask

  task automatic test_back_to_back();
    issue(OP_SW, 32'h20, 32'h1122_3344, 3'b100, 1'b0);
    issue(OP_SB, 32'h21, 32'h0000_00AB, 3'b001, 1'b0);
    issue(OP_LW, 32'h20, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'h1122_AB44) begin bad++; $display("FAIL sb_merge got=%h exp=1122ab44", rdata); end
    issue(OP_SH, 32'h22, 32'h0000_BEEF, 3'b010, 1'b0);
    issue(OP_LW, 32'h20, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'hBEEF_AB44 || rdata_valid !== 1'b1) begin
      bad++; $display("FAIL sh_merge got=%h/%b exp=beefab44/1", rdata, rdata_valid);
    end
    idle();
    total++; if (rdata_valid !== 1'b0 || rdata !== 32'hBEEF_AB44) begin
      bad++; $display("FAIL rdata_hold got=%h/%b exp=beefab44/0", rdata, rdata_valid);
    end
  endtask

  task automatic test_fault();
    issue(OP_SW, 32'h30, 32'h5566_7788, 3'b100, 1'b0);
    issue(OP_SW, 32'h31, 32'hFFFF_FFFF, 3'b100, 1'b1);
    total++; if (fault !== 1'b1 || rdata_valid !== 1'b0) begin
      bad++; $display("FAIL sw_unaligned got=fault%b/rv%b exp=fault1/rv0", fault, rdata_valid);
    end
    idle();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_pulse got=%b exp=0", fault); end
    issue(OP_LW, 32'h30, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'h5566_7788) begin bad++; $display("FAIL fault_nowrite got=%h exp=55667788", rdata); end
    issue(OP_LH, 32'h31, 32'h0, 3'b000, 1'b1);
    total++; if (fault !== 1'b1 || rdata_valid !== 1'b0 || rdata !== 32'h5566_7788) begin
      bad++; $display("FAIL lh_unaligned got=fault%b/rv%b/%h exp=fault1/rv0/55667788", fault, rdata_valid, rdata);
    end
    idle();
  endtask

  task automatic test_wrap();
    issue(OP_SW, 32'h0000_1014, 32'hCAFE_F00D, 3'b100, 1'b0);
    issue(OP_LW, 32'h0000_0014, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL addr_wrap got=%h exp=cafef00d", rdata); end
    idle();
  endtask

`ifdef DM_CLEAR_EN
  task automatic test_clear_restart();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (500) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b1 || dbg_state !== 1'b0) begin
      bad++; $display("FAIL midclear_reset got=busy%b/st%b exp=busy1/st0", busy, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int cyc = 1; cyc <= 1024; cyc++) begin
      if (cyc == 5) begin
        Inst = {OP_SW, 26'h0}; address = 32'h0; wdata = 32'hDEAD_BEEF; size = 3'b100; valid = 1'b1;
      end
      @(negedge clk);
      if (cyc == 5) begin
        total++; if (rdata_valid !== 1'b0 || fault !== 1'b0) begin
          bad++; $display("FAIL busy_store_ignored got=rv%b/fault%b exp=rv0/fault0", rdata_valid, fault);
        end
        Inst = 32'h0; size = 3'b000; valid = 1'b0;
      end
      if (cyc == 1023) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy_1023 got=%b exp=1", busy); end
      end
      if (cyc == 1024) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL restart_busy_1024 got=%b exp=0", busy); end
      end
    end
    issue(OP_LW, 32'h0, 32'h0, 3'b000, 1'b0);
    total++; if (rdata !== 32'h0 || rdata_valid !== 1'b1) begin
      bad++; $display("FAIL busy_store_lw got=%h/%b exp=00000000/1", rdata, rdata_valid);
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
`ifdef DM_CLEAR_EN
    test_clear_restart();
`endif
    test_sw_lb();
    test_unsigned();
    test_back_to_back();
    test_fault();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
